tl_traffic_gen: RTL and testbench
=================================

Name: tl_traffic_gen

Overview:
Synthesizable, self-checking traffic generator and checker for the transaction-layer transfer block (one input FIFO, NUM_CH output port FIFOs).
- Runs the init/threshold sequence, pushes a programmed number of tagged words round-robin across channels under almost-full backpressure, and pops every output port.
- Checks per-channel ordering and payload, then reports done, error and counts.
- Sits beside the DUT on the test harness or FPGA bring-up wrapper, in place of hand-written stimulus.

Parameters:
DATA_W, 12, word width on the DUT FIFO interfaces
NUM_CH, 4, number of DUT output ports (power of two, ≥2)
CH_W, $clog2(NUM_CH), channel tag width in data[DATA_W-1 -: CH_W]
TH_W, 3, threshold field width
CNT_W, 8, width of the word-count and per-channel counters
TIMEOUT, 64, idle cycles allowed in DRAIN before failing

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
cfg_words  in  CNT_W  total words to send (0 is legal)
cfg_umbral_bajo  in  TH_W  low threshold to program
cfg_umbral_alto  in  TH_W  high threshold to program
fifo_almost_full  in  1  DUT input FIFO backpressure
init_out  out  1  DUT init pulse
umbral_bajo_out  out  TH_W  held threshold to DUT
umbral_alto_out  out  TH_W  held threshold to DUT
push_out  out  1  DUT input FIFO push
data_out  out  DATA_W  {channel, payload}
out_valid  in  NUM_CH  per-port non-empty, show-ahead FIFOs
out_data  in  NUM_CH*DATA_W  port i at [i*DATA_W +: DATA_W]
pop_out  out  NUM_CH  per-port pop
busy  out  1  high in INIT, SEND, DRAIN
done  out  1  high in DONE
error  out  1  sticky fail flag, cleared on accepted start
rx_total  out  CNT_W  words received and checked
err_count  out  CNT_W  mismatches, saturating at all-ones

Behaviour:
- Reset (asynchronous, active-low): state IDLE; every output 0; all counters and expected sequence values 0.
- FSM: IDLE -start-> INIT. INIT lasts 2 cycles:
  - cycle 1: latch cfg_* into umbral_*_out; assert init_out.
  - cycle 2: deassert init_out.
  - Then go to SEND, or to DRAIN if cfg_words==0.
- SEND: push_out=1 in any cycle with fifo_almost_full==0 and sent<cfg_words.
  - data_out = {ch, seq[ch]}; ch = sent mod NUM_CH (round-robin); seq[ch] is a per-channel PAY_W=DATA_W-CH_W counter that wraps.
  - push_out and data_out are registered: a decision in cycle n is visible in cycle n+1.
  - fifo_almost_full is sampled in the decision cycle.
  - When the last word is pushed, go to DRAIN.
- DRAIN: wait until rx_total==cfg_words. Go to DONE.
  - The timer counts cycles with no pop; reset it on any pop.
  - Timer reaching TIMEOUT: set error, go to DONE.
- DONE: hold results. A start here restarts the run (the INIT path clears the counters).
- Checker, active in SEND and DRAIN:
  - pop_out[i] = out_valid[i] (combinational, all ports in parallel).
  - On pop: mismatch if the tag field ≠ i, or the payload ≠ exp[i].
  - exp[i] increments on every pop regardless of mismatch.
  - rx_total increments by popcount of pops (saturating).
  - On mismatch: err_count += number of mismatching ports (saturating); error sets.
- End of run: rx_total > cfg_words also sets error.
- Pops outside SEND/DRAIN: none (pop_out=0).
- start while busy: ignored.
- Reset mid-run: immediate return to IDLE, outputs 0.

Decomposition:
- Shared package: state encoding (IDLE, INIT, SEND, DRAIN, DONE), a tag/payload field-slicing function, and a saturating-increment function.
- Sub-module tl_tg_chan_check, instantiated once per channel. It holds exp[i] and produces pop and mismatch for that port.

Test Plan:
1. Reset low for 3 cycles while start=1 -> all outputs 0, state IDLE; after release, still IDLE until start.
2. cfg_words=8, thresholds 2/5, no backpressure, ideal loopback DUT model:
   - init_out high for exactly 1 cycle; umbral outputs 2/5.
   - 8 consecutive pushes; data_out cycles through channel tags 0,1,2,3,0,1,2,3 with payloads 0,0,0,0,1,1,1,1.
   - Result: done=1, rx_total=8, error=0.
3. cfg_words=20 with fifo_almost_full toggled every 3 cycles -> no push in any cycle following a sampled almost-full; 20 words total; done with error=0.
4. Model corrupts the payload of the second word on port 2 -> err_count=1, error=1, rx_total=cfg_words; later port-2 words still checked against the incremented expected value (no cascade).
5. Model drops one word -> DRAIN timeout after 64 idle cycles, error=1, done=1, rx_total=cfg_words-1.
6. cfg_words=0 -> INIT then DRAIN then DONE in 3 cycles, no push, error=0. A start pulse during SEND is ignored.

Source files
------------

// File: rtl/tl_traffic_gen_pkg.sv
// ---------------------------------------------------------------------------
// tl_traffic_gen_pkg
// Shared definitions for the transaction-layer traffic generator/checker:
//   - tg_state_e : top-level run state encoding
//   - tag_of     : extracts the channel tag field from a DUT word
//   - payload_of : extracts the payload field from a DUT word
//   - sat_add    : saturating add used by all result counters
// Field helpers operate on a 32-bit container so one definition serves any
// DATA_W/CH_W combination; callers cast in and out.
// ---------------------------------------------------------------------------
package tl_traffic_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SEND  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } tg_state_e;

  // Tag lives in the top ch_w bits of a data_w-bit word.
  function automatic logic [31:0] tag_of(input logic [31:0] word,
                                         input int data_w, input int ch_w);
    logic [31:0] mask;
    mask = (32'd1 << ch_w) - 32'd1;
    return (word >> (data_w - ch_w)) & mask;
  endfunction

  function automatic logic [31:0] payload_of(input logic [31:0] word,
                                             input int data_w, input int ch_w);
    logic [31:0] mask;
    mask = (32'd1 << (data_w - ch_w)) - 32'd1;
    return word & mask;
  endfunction

  // Returns min(a + b, maxv) without wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] maxv);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, maxv}) ? maxv : s[31:0];
  endfunction

endpackage

// File: rtl/tl_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// tl_traffic_gen_if
// Bundle of the signals between the traffic generator and the transfer block
// under test.
//   master : generator side (drives init/thresholds/push/data/pop)
//   slave  : DUT side (drives almost-full, per-port valid and data)
// out_data packs port i at [i*DATA_W +: DATA_W]; ports are show-ahead FIFOs.
// ---------------------------------------------------------------------------
interface tl_traffic_gen_if #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4,
  parameter int TH_W   = 3
);
  logic                     init_out;
  logic [TH_W-1:0]          umbral_bajo_out;
  logic [TH_W-1:0]          umbral_alto_out;
  logic                     push_out;
  logic [DATA_W-1:0]        data_out;
  logic                     fifo_almost_full;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        pop_out;

  modport master (
    output init_out, umbral_bajo_out, umbral_alto_out, push_out, data_out, pop_out,
    input  fifo_almost_full, out_valid, out_data
  );

  modport slave (
    input  init_out, umbral_bajo_out, umbral_alto_out, push_out, data_out, pop_out,
    output fifo_almost_full, out_valid, out_data
  );
endinterface

// File: rtl/tl_traffic_gen_chan_check.sv
// ---------------------------------------------------------------------------
// tl_tg_chan_check
// Per-output-port checker. Pops whenever the port is non-empty and checking
// is enabled, and flags a mismatch if the popped word carries the wrong tag
// or an unexpected payload. The expected payload advances on every pop, even
// a bad one, so a single corrupted word does not cascade into later errors.
//   clk, reset  : clock, async active-low reset
//   clr_i       : clear expected sequence (start of a run)
//   en_i        : checking window open
//   valid_i     : port non-empty
//   data_i      : port head word (show-ahead)
//   pop_o       : pop this port (combinational)
//   mismatch_o  : popped word is wrong (combinational, qualified by pop)
// ---------------------------------------------------------------------------
module tl_tg_chan_check
  import tl_traffic_gen_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int CH_W   = 2,
  parameter int CH_IDX = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pop_o,
  output logic              mismatch_o
);
  localparam int PAY_W = DATA_W - CH_W;

  logic [PAY_W-1:0] exp_q;
  logic             tag_ok;
  logic             pay_ok;

  assign pop_o      = en_i & valid_i;
  assign tag_ok     = (tag_of(32'(data_i), DATA_W, CH_W) == 32'(CH_IDX));
  assign pay_ok     = (PAY_W'(payload_of(32'(data_i), DATA_W, CH_W)) == exp_q);
  assign mismatch_o = pop_o & ~(tag_ok & pay_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q <= '0;
    end else if (clr_i) begin
      exp_q <= '0;
    end else if (pop_o) begin
      exp_q <= exp_q + 1'b1;
    end
  end
endmodule

// File: rtl/tl_traffic_gen.sv
// ---------------------------------------------------------------------------
// tl_traffic_gen
// Traffic generator and checker for the transaction-layer transfer block.
// Programs thresholds with an init pulse, pushes cfg_words tagged words
// round-robin across channels (respecting almost-full), pops all output
// ports in parallel, checks order/payload per channel and reports results.
//   clk, reset          : clock, async active-low reset
//   start               : one-cycle run request (honoured in IDLE/DONE only)
//   cfg_words           : words to send in this run (0 allowed)
//   cfg_umbral_bajo/alto: thresholds handed to the DUT during INIT
//   dut                 : generator side of the DUT bundle
//   busy / done         : run in progress / run finished
//   error               : sticky failure flag for the current run
//   rx_total            : words popped and checked (saturating)
//   err_count           : mismatching words (saturating)
// ---------------------------------------------------------------------------
module tl_traffic_gen
  import tl_traffic_gen_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int TH_W    = 3,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic [TH_W-1:0]  cfg_umbral_bajo,
  input  logic [TH_W-1:0]  cfg_umbral_alto,
  tl_traffic_gen_if.master dut,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] rx_total,
  output logic [CNT_W-1:0] err_count
);
  localparam int PAY_W = DATA_W - CH_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  tg_state_e         state_q;
  logic              init_ph_q;
  logic              init_q;
  logic              push_q;
  logic [DATA_W-1:0] data_q;
  logic [TH_W-1:0]   ub_q;
  logic [TH_W-1:0]   ua_q;
  logic [CNT_W-1:0]  words_q;
  logic [CNT_W-1:0]  sent_q;
  logic [PAY_W-1:0]  seq_q [NUM_CH];
  logic [TMR_W-1:0]  timer_q;
  logic              error_q;
  logic [CNT_W-1:0]  rx_q;
  logic [CNT_W-1:0]  errc_q;

  logic [CNT_W-1:0]  rx_d;
  logic [CNT_W-1:0]  errc_d;
  logic [CNT_W-1:0]  npop;
  logic [CNT_W-1:0]  nmis;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] mism;
  logic [CH_W-1:0]   ch;
  logic              chk_en;
  logic              clr;

  assign chk_en = (state_q == S_SEND) || (state_q == S_DRAIN);
  // Expected sequences restart while INIT runs; no pops happen there.
  assign clr    = (state_q == S_INIT);
  assign ch     = sent_q[CH_W-1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
    tl_tg_chan_check #(
      .DATA_W (DATA_W),
      .CH_W   (CH_W),
      .CH_IDX (g)
    ) u_chk (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (clr),
      .en_i       (chk_en),
      .valid_i    (dut.out_valid[g]),
      .data_i     (dut.out_data[g*DATA_W +: DATA_W]),
      .pop_o      (pop[g]),
      .mismatch_o (mism[g])
    );
  end

  always_comb begin
    npop = '0;
    nmis = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      npop = npop + CNT_W'(pop[i]);
      nmis = nmis + CNT_W'(mism[i]);
    end
    rx_d   = CNT_W'(sat_add(32'(rx_q), 32'(npop), 32'(CNT_MAX)));
    errc_d = CNT_W'(sat_add(32'(errc_q), 32'(nmis), 32'(CNT_MAX)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      init_ph_q <= 1'b0;
      init_q    <= 1'b0;
      push_q    <= 1'b0;
      data_q    <= '0;
      ub_q      <= '0;
      ua_q      <= '0;
      words_q   <= '0;
      sent_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) seq_q[i] <= '0;
      timer_q   <= '0;
      error_q   <= 1'b0;
      rx_q      <= '0;
      errc_q    <= '0;
    end else begin
      push_q <= 1'b0;
      init_q <= 1'b0;
      if (chk_en) begin
        rx_q   <= rx_d;
        errc_q <= errc_d;
        if (|mism) error_q <= 1'b1;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_INIT;
            init_ph_q <= 1'b0;
            init_q    <= 1'b1;
            ub_q      <= cfg_umbral_bajo;
            ua_q      <= cfg_umbral_alto;
            words_q   <= cfg_words;
            sent_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) seq_q[i] <= '0;
            timer_q   <= '0;
            error_q   <= 1'b0;
            rx_q      <= '0;
            errc_q    <= '0;
          end
        end
        S_INIT: begin
          if (!init_ph_q) begin
            init_ph_q <= 1'b1;
          end else begin
            state_q <= (words_q == '0) ? S_DRAIN : S_SEND;
          end
        end
        S_SEND: begin
          // Decision uses this cycle's almost-full; the word appears next cycle.
          if (!dut.fifo_almost_full && (sent_q < words_q)) begin
            push_q     <= 1'b1;
            data_q     <= {ch, seq_q[ch]};
            seq_q[ch]  <= seq_q[ch] + 1'b1;
            sent_q     <= sent_q + 1'b1;
            if ((sent_q + 1'b1) == words_q) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Compare against the count including this cycle's pops.
          if (rx_d >= words_q) begin
            state_q <= S_DONE;
            if (rx_d > words_q) error_q <= 1'b1;
          end else if (|pop) begin
            timer_q <= '0;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut.init_out        = init_q;
  assign dut.umbral_bajo_out = ub_q;
  assign dut.umbral_alto_out = ua_q;
  assign dut.push_out        = push_q;
  assign dut.data_out        = data_q;
  assign dut.pop_out         = pop;

  assign busy      = (state_q == S_INIT) || (state_q == S_SEND) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign rx_total  = rx_q;
  assign err_count = errc_q;
endmodule

// File: tb/tb_tl_traffic_gen.sv
module tb_tl_traffic_gen;
  localparam int DW  = 12;
  localparam int NCH = 4;
  localparam int THW = 3;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CW-1:0]  cfg_words;
  logic [THW-1:0] lo;
  logic [THW-1:0] hi;
  logic           busy;
  logic           done;
  logic           error;
  logic [CW-1:0]  rx_total;
  logic [CW-1:0]  err_count;

  tl_traffic_gen_if #(.DATA_W(DW), .NUM_CH(NCH), .TH_W(THW)) bus();

  tl_traffic_gen #(
    .DATA_W(DW), .NUM_CH(NCH), .TH_W(THW), .CNT_W(CW), .TIMEOUT(64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_words       (cfg_words),
    .cfg_umbral_bajo (lo),
    .cfg_umbral_alto (hi),
    .dut             (bus.master),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .rx_total        (rx_total),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Loopback model of the transfer block: one queue per output port,
  // routed by tag, optionally corrupting or dropping one word per run.
  logic [DW-1:0]     q [NCH][$];
  int                push_idx;
  int                corrupt_idx = -1;
  int                drop_idx    = -1;
  logic [DW-1:0]     m_w;
  logic [NCH-1:0]    m_pops;
  logic [NCH-1:0]    m_nv;
  logic [NCH*DW-1:0] m_nd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) q[i].delete();
      push_idx = 0;
      bus.out_valid <= '0;
      bus.out_data  <= '0;
    end else begin
      m_pops = bus.pop_out;
      if (bus.init_out) begin
        for (int i = 0; i < NCH; i++) q[i].delete();
        push_idx = 0;
      end
      for (int i = 0; i < NCH; i++)
        if (m_pops[i] && q[i].size() != 0) void'(q[i].pop_front());
      if (bus.push_out) begin
        m_w = bus.data_out;
        if (push_idx == corrupt_idx) m_w[0] = ~m_w[0];
        if (push_idx != drop_idx) q[m_w[DW-1 -: 2]].push_back(m_w);
        push_idx++;
      end
      for (int i = 0; i < NCH; i++) begin
        m_nv[i]           = (q[i].size() != 0);
        m_nd[i*DW +: DW]  = (q[i].size() != 0) ? q[i][0] : '0;
      end
      bus.out_valid <= m_nv;
      bus.out_data  <= m_nd;
    end
  end

  typedef struct {
    int         words;
    logic [2:0] lo;
    logic [2:0] hi;
    int         af_mode;
    int         corrupt;
    int         drop;
    int         exp_err;
    int         exp_rx;
    int         exp_ec;
    int         exp_push;
  } vec_t;

  vec_t          vt [5];
  logic [DW-1:0] push_log [$];
  int            first_push;
  int            last_push;

  task automatic run_vec(input vec_t v, output int pushes, output int init_cyc,
                         output int af_viol, output int cyc, output bit timed_out);
    bit af_prev;
    bit af_now;
    corrupt_idx = v.corrupt;
    drop_idx    = v.drop;
    cfg_words   = CW'(v.words);
    lo          = v.lo;
    hi          = v.hi;
    push_log.delete();
    pushes = 0; init_cyc = 0; af_viol = 0; timed_out = 1'b1; af_prev = 1'b0;
    first_push = -1; last_push = -1;
    @(negedge clk);
    bus.fifo_almost_full = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 600; cyc++) begin
      if (bus.init_out) init_cyc++;
      if (bus.push_out) begin
        pushes++;
        push_log.push_back(bus.data_out);
        if (first_push < 0) first_push = cyc;
        last_push = cyc;
        if (af_prev) af_viol++;
      end
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      af_now = (v.af_mode == 1) && (((cyc / 3) % 2) == 1);
      bus.fifo_almost_full = af_now;
      af_prev = af_now;
      @(negedge clk);
    end
    bus.fifo_almost_full = 1'b0;
  endtask

  initial begin
    int pushes, init_cyc, af_viol, cyc, n;
    bit to;
    logic [DW-1:0] w;

    // Reset held with start asserted: everything quiet.
    reset = 1'b0; start = 1'b1; cfg_words = 8'd5; lo = 3'd1; hi = 3'd6;
    bus.fifo_almost_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", int'({bus.init_out, bus.push_out, bus.pop_out, busy, done, error}), 0);
    check("rst_counts", int'({rx_total, err_count}), 0);
    check("rst_umbral", int'({bus.umbral_bajo_out, bus.umbral_alto_out}), 0);
    check("rst_data", int'(bus.data_out), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", int'({busy, done, bus.push_out}), 0);

    //             words lo hi af cor drp err rx ec push
    vt[0] = '{  8, 3'd2, 3'd5, 0, -1, -1, 0,  8, 0,  8};
    vt[1] = '{ 20, 3'd1, 3'd6, 1, -1, -1, 0, 20, 0, 20};
    vt[2] = '{ 12, 3'd3, 3'd4, 0,  6, -1, 1, 12, 1, 12};
    vt[3] = '{ 10, 3'd2, 3'd5, 0, -1,  9, 1,  9, 0, 10};
    vt[4] = '{  0, 3'd4, 3'd7, 0, -1, -1, 0,  0, 0,  0};

    for (int k = 0; k < 5; k++) begin
      run_vec(vt[k], pushes, init_cyc, af_viol, cyc, to);
      check($sformatf("v%0d_timeout", k), int'(to), 0);
      check($sformatf("v%0d_done", k), int'(done), 1);
      check($sformatf("v%0d_busy", k), int'(busy), 0);
      check($sformatf("v%0d_error", k), int'(error), vt[k].exp_err);
      check($sformatf("v%0d_rx_total", k), int'(rx_total), vt[k].exp_rx);
      check($sformatf("v%0d_err_count", k), int'(err_count), vt[k].exp_ec);
      check($sformatf("v%0d_pushes", k), pushes, vt[k].exp_push);
      check($sformatf("v%0d_init_cycles", k), init_cyc, 1);
      check($sformatf("v%0d_af_push", k), af_viol, 0);
      check($sformatf("v%0d_umbral_bajo", k), int'(bus.umbral_bajo_out), int'(vt[k].lo));
      check($sformatf("v%0d_umbral_alto", k), int'(bus.umbral_alto_out), int'(vt[k].hi));
      if (k == 0) begin
        check("v0_consecutive", last_push - first_push, 7);
        n = push_log.size();
        for (int i = 0; i < 8 && i < n; i++) begin
          w = push_log[i];
          check($sformatf("v0_word%0d", i), int'(w), ((i % 4) << 10) | (i / 4));
        end
      end
      if (k == 3) check("v3_drain_wait", int'(cyc >= 64), 1);
      if (k == 4) check("v4_cycles_to_done", cyc, 3);
    end

    // start pulse while SEND is stalled by almost-full must be ignored.
    corrupt_idx = -1; drop_idx = -1;
    cfg_words = 8'd8; lo = 3'd2; hi = 3'd5;
    @(negedge clk);
    bus.fifo_almost_full = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_busy", int'(busy), 1);
    check("stall_no_push", int'(bus.push_out), 0);
    cfg_words = 8'd3; lo = 3'd7; hi = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.fifo_almost_full = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ign_done", int'(done), 1);
    check("ign_rx_total", int'(rx_total), 8);
    check("ign_umbral_bajo", int'(bus.umbral_bajo_out), 2);
    check("ign_error", int'(error), 0);

    // Reset mid-run returns straight to IDLE.
    cfg_words = 8'd20; lo = 3'd3; hi = 3'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy_before", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_ctrl", int'({bus.init_out, bus.push_out, bus.pop_out, busy, done, error}), 0);
    check("mid_rst_out", int'({bus.umbral_alto_out, rx_total, err_count}), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_idle", int'({busy, done}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
